risc_hazard_controller: RTL and testbench
=========================================

Name: risc_hazard_controller

Overview:
- Pipeline sequencer for the RISC DOF→EX→WB datapath.
- Detects read-after-write hazards between the instruction in DOF and the instructions in flight in EX/WB. On a hazard it stalls PC/IR and injects bubbles into EX.
- Resolves branches from EX status (Z, BS, PS), selects the next-PC source and squashes wrong-path instructions for a fixed number of cycles.
- Keeps a saturating stall-cycle counter for debug.

Parameters:
- REG_W, 5, register address width
- FLUSH_SLOTS, 2, consecutive cycles bubble is held after a taken branch (1..3)
- CNT_W, 16, width of stall_count

Ports:
- CLK  input  1  clock; all state updates on negedge CLK, same edge as the pipeline registers
- reset  input  1  synchronous, active-high
- AA  input  REG_W  DOF source register A address
- BA  input  REG_W  DOF source register B address
- use_A  input  1  DOF instruction reads register A
- use_B  input  1  DOF instruction reads register B (MB=0)
- RW_dof  input  1  DOF instruction writes the register file
- DA_dof  input  REG_W  DOF destination register
- BS_ex  input  2  EX branch select
- PS_ex  input  1  EX branch polarity
- Z_ex  input  1  EX zero flag
- stall  output  1  hold PC and IR this cycle
- bubble  output  1  force RW/MW/BS into EX to 0 this cycle
- PC_sel  output  2  00 PC+1, 01 BrA, 10 RAA
- branch_taken  output  1  EX branch resolved taken
- stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- State machine: RUN, FLUSH. Reset → RUN, flush_cnt=0, scoreboard cleared, stall_count=0.
- Outputs while reset is high: stall=0, bubble=0, PC_sel=00, branch_taken=0.
- Scoreboard: two slots, SB_EX and SB_WB, each holding {valid, DA}. On each negedge:
  - SB_WB←SB_EX.
  - SB_EX←{RW_dof & ~bubble & (DA_dof≠0), DA_dof}.
- Branch decode is combinational from the EX inputs:
  - BS=00: not taken.
  - BS=01: taken = Z_ex ^ PS_ex.
  - BS=10: taken, PC_sel=10.
  - BS=11: taken, PC_sel=01.
  - BS=01 taken gives PC_sel=01. Not taken gives PC_sel=00.
- branch_taken is combinational. It is forced to 0 while in FLUSH, because the EX instruction is then a bubble.
- Hazard (combinational):
  - (use_A & AA≠0 & matches a valid slot's DA), OR the same test on B.
  - R0 never hazards.
- Priority: reset > branch_taken > FLUSH > hazard.
- In RUN:
  - branch_taken: bubble=1, stall=0. If FLUSH_SLOTS>1, go to FLUSH with flush_cnt=FLUSH_SLOTS-1.
  - Hazard (no branch): stall=1, bubble=1; stay in RUN.
  - Otherwise: stall=0, bubble=0.
- In FLUSH:
  - bubble=1, stall=0, and hazard is ignored.
  - flush_cnt decrements each cycle; return to RUN when it reaches 1→0.
- Stall duration: at most 2 consecutive cycles per producer, because the bubble shifts the producer out of the scoreboard.
- stall_count increments on every negedge with stall=1 and saturates at 2^CNT_W-1. It does not wrap.
- Simultaneous branch and hazard: the branch wins, with no stall, since the DOF instruction is squashed.
- Reset asserted mid-FLUSH or mid-stall: next state is RUN, the scoreboard is cleared, and outputs are idle in the following cycle.

Decomposition:
- Shared package `risc_pkg`:
  - BS encodings BS_NONE, BS_COND, BS_JR, BS_JMP.
  - PC_sel encodings PCS_INC, PCS_BRA, PCS_RAA.
  - FSM state typedef.
- One sub-module, `risc_scoreboard`: the 2-slot shift register plus dual-address match. Outputs hit_A and hit_B.

Test Plan:
- R1←R2+R3 (RW_dof=1, DA=1), then AA=1, use_A=1 → stall=1 and bubble=1 for 2 cycles, then stall=0; stall_count=2.
- Producer DA=0, RW=1, then AA=0 use_A=1 → no stall.
- BS_ex=01, PS=0, Z=1 → branch_taken=1, PC_sel=01, bubble=1 for 2 cycles. With Z=0 → PC_sel=00, bubble=0.
- BS_ex=10 in the same cycle as a DOF hazard on BA → PC_sel=10, stall=0, bubble=1; FLUSH follows.
- Reset pulsed during the second FLUSH cycle → next cycle bubble=0, stall=0, scoreboard empty (an AA that previously matched does not stall).
- Force stall continuously with CNT_W=4 → stall_count holds at 15.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared encodings for the RISC DOF->EX->WB pipeline sequencer.
package risc_pkg;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JR   = 2'b10;
    localparam logic [1:0] BS_JMP  = 2'b11;

    localparam logic [1:0] PCS_INC = 2'b00;
    localparam logic [1:0] PCS_BRA = 2'b01;
    localparam logic [1:0] PCS_RAA = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hc_state_t;

endpackage

// File: rtl/risc_scoreboard.sv
// Two-slot destination tracker (EX, WB) with dual source-address match for RAW detection.
module risc_scoreboard
    import risc_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [REG_W-1:0] wr_da,
    input  logic [REG_W-1:0] AA,
    input  logic [REG_W-1:0] BA,
    input  logic             use_A,
    input  logic             use_B,
    output logic             hit_A,
    output logic             hit_B
);

    logic             vld_p1, vld_p2;
    logic [REG_W-1:0] da_p1, da_p2;

    // EX slot (p1) -> WB slot (p2)
    always_ff @(negedge CLK) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= wr_en;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(negedge CLK) begin
        da_p1 <= wr_da;
        da_p2 <= da_p1;
    end

    // R0 is hardwired, so reading it can never depend on an older write
    assign hit_A = use_A && (AA != '0) &&
                   ((vld_p1 && (da_p1 == AA)) || (vld_p2 && (da_p2 == AA)));
    assign hit_B = use_B && (BA != '0) &&
                   ((vld_p1 && (da_p1 == BA)) || (vld_p2 && (da_p2 == BA)));

endmodule

// File: rtl/risc_hazard_controller.sv
// Pipeline sequencer: RAW stall/bubble insertion, branch resolution with wrong-path flush,
// and a saturating stall-cycle debug counter.
module risc_hazard_controller
    import risc_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [REG_W-1:0] AA,
    input  logic [REG_W-1:0] BA,
    input  logic             use_A,
    input  logic             use_B,
    input  logic             RW_dof,
    input  logic [REG_W-1:0] DA_dof,
    input  logic [1:0]       BS_ex,
    input  logic             PS_ex,
    input  logic             Z_ex,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       PC_sel,
    output logic             branch_taken,
    output logic [CNT_W-1:0] stall_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    hc_state_t  state, state_nxt;
    logic [1:0] flush_cnt, flush_cnt_nxt;
    logic       hit_A, hit_B, hazard;
    logic       taken_raw;
    logic [1:0] pcs_raw;
    logic       sb_wr_en;

    assign sb_wr_en = RW_dof && !bubble && (DA_dof != '0);
    assign hazard   = hit_A || hit_B;

    risc_scoreboard #(.REG_W(REG_W)) u_sb (
        .CLK   (CLK),
        .reset (reset),
        .wr_en (sb_wr_en),
        .wr_da (DA_dof),
        .AA    (AA),
        .BA    (BA),
        .use_A (use_A),
        .use_B (use_B),
        .hit_A (hit_A),
        .hit_B (hit_B)
    );

    always_comb begin
        taken_raw = 1'b0;
        pcs_raw   = PCS_INC;
        case (BS_ex)
            BS_COND: begin
                taken_raw = Z_ex ^ PS_ex;
                pcs_raw   = taken_raw ? PCS_BRA : PCS_INC;
            end
            BS_JR: begin
                taken_raw = 1'b1;
                pcs_raw   = PCS_RAA;
            end
            BS_JMP: begin
                taken_raw = 1'b1;
                pcs_raw   = PCS_BRA;
            end
            default: ;
        endcase
    end

    // A taken branch squashes the DOF instruction, so it outranks any hazard on it
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        stall         = 1'b0;
        bubble        = 1'b0;
        branch_taken  = 1'b0;
        PC_sel        = PCS_INC;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (taken_raw) begin
                        branch_taken = 1'b1;
                        PC_sel       = pcs_raw;
                        bubble       = 1'b1;
                        if (FLUSH_SLOTS > 1) begin
                            state_nxt     = ST_FLUSH;
                            flush_cnt_nxt = 2'(FLUSH_SLOTS - 1);
                        end
                    end else if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    bubble        = 1'b1;
                    flush_cnt_nxt = flush_cnt - 2'd1;
                    if (flush_cnt <= 2'd1) begin
                        state_nxt     = ST_RUN;
                        flush_cnt_nxt = 2'd0;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(negedge CLK) begin
        if (reset) begin
            state       <= ST_RUN;
            flush_cnt   <= 2'd0;
            stall_count <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (stall) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

endmodule

// File: tb/tb_risc_hazard_controller.sv
// Directed bench for risc_hazard_controller: hazards, branches, flush, reset and counter saturation.
module tb_risc_hazard_controller;
    import risc_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic [4:0]  AA, BA, DA_dof;
    logic        use_A, use_B, RW_dof;
    logic [1:0]  BS_ex;
    logic        PS_ex, Z_ex;

    logic        stall, bubble, branch_taken;
    logic [1:0]  PC_sel;
    logic [15:0] cnt16;
    logic        stall4, bubble4, taken4;
    logic [1:0]  pcsel4;
    logic [3:0]  cnt4;
    logic [4:0]  ctl, ctl4;

    int n_checks = 0;
    int n_fail   = 0;

    assign ctl  = {stall, bubble, branch_taken, PC_sel};
    assign ctl4 = {stall4, bubble4, taken4, pcsel4};

    always #5 CLK = ~CLK;

    risc_hazard_controller #(.REG_W(5), .FLUSH_SLOTS(2), .CNT_W(16)) dut (
        .CLK(CLK), .reset(reset), .AA(AA), .BA(BA), .use_A(use_A), .use_B(use_B),
        .RW_dof(RW_dof), .DA_dof(DA_dof), .BS_ex(BS_ex), .PS_ex(PS_ex), .Z_ex(Z_ex),
        .stall(stall), .bubble(bubble), .PC_sel(PC_sel), .branch_taken(branch_taken),
        .stall_count(cnt16)
    );

    risc_hazard_controller #(.REG_W(5), .FLUSH_SLOTS(2), .CNT_W(4)) dut4 (
        .CLK(CLK), .reset(reset), .AA(AA), .BA(BA), .use_A(use_A), .use_B(use_B),
        .RW_dof(RW_dof), .DA_dof(DA_dof), .BS_ex(BS_ex), .PS_ex(PS_ex), .Z_ex(Z_ex),
        .stall(stall4), .bubble(bubble4), .PC_sel(pcsel4), .branch_taken(taken4),
        .stall_count(cnt4)
    );

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        reset = 1'b0; AA = '0; BA = '0; use_A = 1'b0; use_B = 1'b0;
        RW_dof = 1'b0; DA_dof = '0; BS_ex = BS_NONE; PS_ex = 1'b0; Z_ex = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ctl = {stall, bubble, branch_taken, PC_sel}
    task automatic test_reset();
        idle();
        reset = 1'b1; BS_ex = BS_JMP; AA = 5'd1; use_A = 1'b1;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL reset_outputs: ctl=%b expected 00000", ctl); end
        tick();
        idle();
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL reset_idle_after: ctl=%b expected 00000", ctl); end
        n_checks++;
        if (cnt16 !== 16'd0 || cnt4 !== 4'd0) begin n_fail++; $display("FAIL reset_count: cnt16=%0d cnt4=%0d expected 0", cnt16, cnt4); end
        tick();
    endtask

    task automatic test_raw_hazard();
        do_reset();
        RW_dof = 1'b1; DA_dof = 5'd1;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL raw_producer: ctl=%b expected 00000", ctl); end
        tick();
        RW_dof = 1'b0; DA_dof = 5'd0; use_A = 1'b1; AA = 5'd1;
        settle();
        n_checks++;
        if (ctl !== 5'b11000) begin n_fail++; $display("FAIL raw_stall_ex: ctl=%b expected 11000", ctl); end
        tick();
        settle();
        n_checks++;
        if (ctl !== 5'b11000) begin n_fail++; $display("FAIL raw_stall_wb: ctl=%b expected 11000", ctl); end
        tick();
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL raw_release: ctl=%b expected 00000", ctl); end
        n_checks++;
        if (cnt16 !== 16'd2) begin n_fail++; $display("FAIL raw_count: stall_count=%0d expected 2", cnt16); end
        tick();
    endtask

    task automatic test_r0_and_b();
        do_reset();
        RW_dof = 1'b1; DA_dof = 5'd0;
        settle();
        tick();
        RW_dof = 1'b0; use_A = 1'b1; AA = 5'd0; use_B = 1'b1; BA = 5'd0;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL r0_no_stall: ctl=%b expected 00000", ctl); end
        tick();
        idle();
        RW_dof = 1'b1; DA_dof = 5'd5;
        settle();
        tick();
        RW_dof = 1'b0; use_A = 1'b1; AA = 5'd3; use_B = 1'b0; BA = 5'd5;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL b_unused_no_stall: ctl=%b expected 00000", ctl); end
        use_B = 1'b1;
        settle();
        n_checks++;
        if (ctl !== 5'b11000) begin n_fail++; $display("FAIL b_hazard_ex: ctl=%b expected 11000", ctl); end
        tick();
        settle();
        n_checks++;
        if (ctl !== 5'b11000) begin n_fail++; $display("FAIL b_hazard_wb: ctl=%b expected 11000", ctl); end
        tick();
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL b_release: ctl=%b expected 00000", ctl); end
        tick();
    endtask

    task automatic test_branch_cond();
        do_reset();
        BS_ex = BS_COND; PS_ex = 1'b0; Z_ex = 1'b1;
        settle();
        n_checks++;
        if (ctl !== 5'b01101) begin n_fail++; $display("FAIL cond_taken: ctl=%b expected 01101", ctl); end
        tick();
        BS_ex = BS_JMP;
        settle();
        n_checks++;
        if (ctl !== 5'b01000) begin n_fail++; $display("FAIL cond_flush: ctl=%b expected 01000", ctl); end
        tick();
        BS_ex = BS_COND; PS_ex = 1'b0; Z_ex = 1'b0;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL cond_not_taken: ctl=%b expected 00000", ctl); end
        PS_ex = 1'b1; Z_ex = 1'b1;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL cond_inv_not_taken: ctl=%b expected 00000", ctl); end
        Z_ex = 1'b0;
        settle();
        n_checks++;
        if (ctl !== 5'b01101) begin n_fail++; $display("FAIL cond_inv_taken: ctl=%b expected 01101", ctl); end
        tick();
        BS_ex = BS_NONE;
        settle();
        n_checks++;
        if (ctl !== 5'b01000) begin n_fail++; $display("FAIL cond_inv_flush: ctl=%b expected 01000", ctl); end
        tick();
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL cond_back_to_run: ctl=%b expected 00000", ctl); end
        tick();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        RW_dof = 1'b1; DA_dof = 5'd4;
        settle();
        tick();
        RW_dof = 1'b0; use_B = 1'b1; BA = 5'd4; BS_ex = BS_JR;
        settle();
        n_checks++;
        if (ctl !== 5'b01110) begin n_fail++; $display("FAIL jr_over_hazard: ctl=%b expected 01110", ctl); end
        tick();
        BS_ex = BS_NONE;
        settle();
        n_checks++;
        if (ctl !== 5'b01000) begin n_fail++; $display("FAIL jr_flush_ignores_hazard: ctl=%b expected 01000", ctl); end
        tick();
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL jr_after_flush: ctl=%b expected 00000", ctl); end
        n_checks++;
        if (cnt16 !== 16'd0) begin n_fail++; $display("FAIL jr_count: stall_count=%0d expected 0", cnt16); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        RW_dof = 1'b1; DA_dof = 5'd7;
        settle();
        tick();
        RW_dof = 1'b0; BS_ex = BS_JMP;
        settle();
        n_checks++;
        if (ctl !== 5'b01101) begin n_fail++; $display("FAIL rmf_jmp: ctl=%b expected 01101", ctl); end
        tick();
        reset = 1'b1; BS_ex = BS_NONE; RW_dof = 1'b1; DA_dof = 5'd7;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL rmf_in_reset: ctl=%b expected 00000", ctl); end
        tick();
        reset = 1'b0; RW_dof = 1'b0; DA_dof = 5'd0; use_A = 1'b1; AA = 5'd7;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL rmf_sb_cleared: ctl=%b expected 00000", ctl); end
        tick();
        do_reset();
        RW_dof = 1'b1; DA_dof = 5'd9;
        settle();
        tick();
        RW_dof = 1'b0; use_A = 1'b1; AA = 5'd9; reset = 1'b1;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL rms_in_reset: ctl=%b expected 00000", ctl); end
        tick();
        reset = 1'b0;
        settle();
        n_checks++;
        if (ctl !== 5'b00000) begin n_fail++; $display("FAIL rms_sb_cleared: ctl=%b expected 00000", ctl); end
        n_checks++;
        if (cnt16 !== 16'd0) begin n_fail++; $display("FAIL rms_count: stall_count=%0d expected 0", cnt16); end
        tick();
    endtask

    // Constant self-dependent producer/consumer: stalls on cycles where i%3 != 0
    task automatic test_saturate();
        logic e;
        do_reset();
        RW_dof = 1'b1; DA_dof = 5'd1; use_A = 1'b1; AA = 5'd1;
        for (int i = 0; i < 30; i++) begin
            e = (i % 3) != 0;
            settle();
            n_checks++;
            if (ctl4 !== {e, e, 3'b000} || ctl !== {e, e, 3'b000}) begin
                n_fail++;
                $display("FAIL sat_pattern[%0d]: ctl=%b ctl4=%b expected %b", i, ctl, ctl4, {e, e, 3'b000});
            end
            tick();
            if (i == 20) begin
                n_checks++;
                if (cnt4 !== 4'd14) begin n_fail++; $display("FAIL sat_before: cnt4=%0d expected 14", cnt4); end
            end
        end
        n_checks++;
        if (cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_hold: cnt4=%0d expected 15", cnt4); end
        n_checks++;
        if (cnt16 !== 16'd20) begin n_fail++; $display("FAIL sat_wide: cnt16=%0d expected 20", cnt16); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw_hazard();
        test_r0_and_b();
        test_branch_cond();
        test_branch_hazard();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
